// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and transmitter states.
// The receiver is expected to import this package too.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clk_t cycle of each serial bit.
// clear re-phases the count so every frame starts on a bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_t,
  input  logic srst,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_t or posedge srst) begin
    if (srst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, serialised as start, 8 data bits
// LSB first, optional even parity, then STOP_BITS stop bits on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_t,
  input  logic       srst,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int               BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e                  state_q, state_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       parity_q, parity_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic                       tx_d;
  logic                       handshake;
  logic                       bit_tick;

  assign tx_ready  = (state_q == TX_IDLE) && !srst;
  assign handshake = tx_valid && tx_ready;
  assign busy      = (state_q != TX_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_t    (clk_t),
    .srst     (srst),
    .clear    (handshake),
    .en       (busy),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk_t or posedge srst) begin
    if (srst) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx        <= UART_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    tx_done   = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (handshake) begin
          state_d   = TX_START;
          shift_d   = data_in;
          parity_d  = ^data_in;
          bit_cnt_d = '0;
        end
      end
      TX_START: begin
        if (bit_tick) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_tick) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = TX_IDLE;
            tx_done   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx itself stays a flop.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = parity_d;
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, slow-baud and no-parity/two-stop builds,
// with a per-cycle line check and a small receiver model decoding each frame.
module tb_uart_tx;

  logic clk_t = 1'b0;
  always #5 clk_t = ~clk_t;

  // Instance a: defaults
  logic       a_srst, a_valid, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data;
  // Instance b: CLKS_PER_BIT=4
  logic       b_srst, b_valid, b_ready, b_tx, b_busy, b_done;
  logic [7:0] b_data;
  // Instance c: PARITY_EN=0, STOP_BITS=2
  logic       c_srst, c_valid, c_ready, c_tx, c_busy, c_done;
  logic [7:0] c_data;

  uart_tx u_a (
    .clk_t(clk_t), .srst(a_srst), .data_in(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx(a_tx), .busy(a_busy), .tx_done(a_done)
  );

  uart_tx #(.CLKS_PER_BIT(4)) u_b (
    .clk_t(clk_t), .srst(b_srst), .data_in(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx(b_tx), .busy(b_busy), .tx_done(b_done)
  );

  uart_tx #(.PARITY_EN(0), .STOP_BITS(2)) u_c (
    .clk_t(clk_t), .srst(c_srst), .data_in(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx(c_tx), .busy(c_busy), .tx_done(c_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_t);
    #1;
  endtask

  // Sends one byte on instance a; exp lists the 11 line levels in transmission
  // order (leftmost first). tx_valid stays high through the frame while data_in
  // is scrambled, and is dropped only after the block is idle again.
  task automatic frame_a(input string tag, input logic [7:0] b, input logic [10:0] exp,
                         input logic exp_par);
    logic [10:0] cap;
    logic [7:0]  rx_byte;
    int          w;
    w = 0;
    while (!a_ready && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_ready_wait"}, a_ready, 1'b1);
    a_data  = b;
    a_valid = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) begin
      cap[k] = a_tx;
      check($sformatf("%s_tx%0d", tag, k), a_tx, exp[10-k]);
      check($sformatf("%s_done%0d", tag, k), a_done, (k == 10));
      check($sformatf("%s_busy%0d", tag, k), a_busy, 1'b1);
      check($sformatf("%s_rdy%0d", tag, k), a_ready, 1'b0);
      a_data = 8'($urandom);
      tick();
    end
    check({tag, "_idle_ready"}, a_ready, 1'b1);
    check({tag, "_idle_busy"}, a_busy, 1'b0);
    check({tag, "_idle_tx"}, a_tx, 1'b1);
    for (int i = 0; i < 8; i++) rx_byte[i] = cap[i+1];
    check({tag, "_rx_start"}, cap[0], 1'b0);
    check({tag, "_rx_data"}, rx_byte, b);
    check({tag, "_rx_parity"}, cap[9], exp_par);
    check({tag, "_rx_stop"}, cap[10], 1'b1);
    a_valid = 1'b0;
  endtask

  initial begin
    a_srst = 1'b1; b_srst = 1'b1; c_srst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;

    #3;
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_done", a_done, 1'b0);
    repeat (2) tick();
    a_srst = 1'b0; b_srst = 1'b0; c_srst = 1'b0;
    #1;
    check("post_rst_ready", a_ready, 1'b1);
    check("post_rst_tx", a_tx, 1'b1);
    tick();

    // Single byte with default parameters
    frame_a("a5", 8'hA5, 11'b01010010101, 1'b0);
    tick();

    // Loopback stream with tx_valid held high between frames
    frame_a("lb00", 8'h00, 11'b00000000001, 1'b0);
    a_valid = 1'b1;
    frame_a("lb01", 8'h01, 11'b01000000011, 1'b1);
    a_valid = 1'b1;
    frame_a("lbff", 8'hFF, 11'b01111111101, 1'b0);
    a_valid = 1'b1;
    frame_a("lb3c", 8'h3C, 11'b00011110001, 1'b0);
    tick();

    // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the jump to 1 is visible)
    a_data  = 8'hC3;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    repeat (4) tick();
    check("mid_bit3_tx", a_tx, 1'b0);
    check("mid_bit3_busy", a_busy, 1'b1);
    #2;
    a_srst = 1'b1;
    #1;
    check("async_rst_tx", a_tx, 1'b1);
    check("async_rst_busy", a_busy, 1'b0);
    check("async_rst_ready", a_ready, 1'b0);
    check("async_rst_done", a_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held_rst_done%0d", i), a_done, 1'b0);
      check($sformatf("held_rst_tx%0d", i), a_tx, 1'b1);
    end
    a_srst = 1'b0;
    tick();
    check("rel_ready", a_ready, 1'b1);
    check("rel_tx", a_tx, 1'b1);
    frame_a("5a", 8'h5A, 11'b00101101001, 1'b0);
    tick();

    // CLKS_PER_BIT=4: 0x01 gives a 44-cycle frame
    begin
      logic [10:0] vb;
      vb = 11'b01000000011;
      b_data  = 8'h01;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      for (int i = 0; i < 44; i++) begin
        check($sformatf("cpb4_tx%0d", i), b_tx, vb[10 - i/4]);
        check($sformatf("cpb4_busy%0d", i), b_busy, 1'b1);
        check($sformatf("cpb4_done%0d", i), b_done, (i == 43));
        tick();
      end
      check("cpb4_end_busy", b_busy, 1'b0);
      check("cpb4_end_ready", b_ready, 1'b1);
      check("cpb4_end_tx", b_tx, 1'b1);
    end
    tick();

    // No parity, two stop bits: 0x80 gives an 11-cycle frame
    begin
      logic [10:0] vc;
      vc = 11'b00000000111;
      c_data  = 8'h80;
      c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
        check($sformatf("p0s2_tx%0d", i), c_tx, vc[10-i]);
        check($sformatf("p0s2_busy%0d", i), c_busy, 1'b1);
        check($sformatf("p0s2_done%0d", i), c_done, (i == 10));
        tick();
      end
      check("p0s2_end_busy", c_busy, 1'b0);
      check("p0s2_end_ready", c_ready, 1'b1);
      check("p0s2_end_tx", c_tx, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
